// File: rtl/chan_mux_rr.sv
// chan_mux_rr: NCH-channel to single-output multiplexer with a one-entry
// registered output stage. Fixed-select or round-robin arbitration chooses
// the channel handed the single in_ready strobe each cycle.
module chan_mux_rr #(
    parameter  int NCH   = 8,
    parameter  int WIDTH = 8,
    localparam int SELW  = (NCH > 2) ? $clog2(NCH) : 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NCH*WIDTH-1:0] in_data,
    input  logic [NCH-1:0]       in_valid,
    output logic [NCH-1:0]       in_ready,
    input  logic                 mode,
    input  logic [SELW-1:0]      sel,
    output logic [WIDTH-1:0]     out_data,
    output logic [SELW-1:0]      out_chan,
    output logic                 out_valid,
    input  logic                 out_ready
);

    // Channel count and last index at the widths used for index arithmetic.
    // The extra bit keeps NCH itself representable when NCH is a power of two.
    localparam logic [SELW:0]   NCH_L  = (SELW+1)'(NCH);
    localparam logic [SELW-1:0] LAST_L = SELW'(NCH - 1);

    // Increment a channel index, wrapping from the last channel back to 0.
    function automatic logic [SELW-1:0] wrap_inc(input logic [SELW-1:0] idx);
        if (idx == LAST_L) begin
            wrap_inc = '0;
        end else begin
            wrap_inc = idx + 1'b1;
        end
    endfunction

    // Output register and round-robin pointer state.
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] out_data_q,  out_data_d;
    logic [SELW-1:0]  out_chan_q,  out_chan_d;
    logic [SELW-1:0]  rr_ptr_q,    rr_ptr_d;

    // Arbitration results.
    logic             load_en;
    logic [SELW:0]    rr_idx;
    logic             rr_found;
    logic [SELW-1:0]  rr_grant;
    logic             grant_vld;
    logic [SELW-1:0]  grant;
    logic [WIDTH-1:0] grant_data;
    logic             xfer;

    // The output register can accept a word when empty or being drained now.
    assign load_en = !out_valid_q || out_ready;

    // Round-robin search: first valid channel at or above rr_ptr, wrapping.
    always_comb begin
        rr_found = 1'b0;
        rr_grant = '0;
        rr_idx   = '0;
        for (int k = 0; k < NCH; k++) begin
            rr_idx = {1'b0, rr_ptr_q} + (SELW+1)'(k);
            if (rr_idx >= NCH_L) begin
                rr_idx = rr_idx - NCH_L;
            end
            if (!rr_found && in_valid[rr_idx[SELW-1:0]]) begin
                rr_found = 1'b1;
                rr_grant = rr_idx[SELW-1:0];
            end
        end
    end

    // Pick the granted channel for the active mode. An out-of-range sel in
    // fixed mode grants nobody; grant is parked at 0 so the data mux below
    // never indexes past the input bus.
    always_comb begin
        grant_vld = 1'b0;
        grant     = '0;
        if (mode) begin
            grant_vld = rr_found;
            grant     = rr_grant;
        end else if ({1'b0, sel} < NCH_L) begin
            grant_vld = 1'b1;
            grant     = sel;
        end
    end

    // Single ready strobe to the granted channel. In fixed mode it is offered
    // regardless of that channel's valid; reset masks it so nothing is taken.
    always_comb begin
        in_ready = '0;
        if (!rst && grant_vld && load_en) begin
            in_ready[grant] = 1'b1;
        end
    end

    assign xfer       = |(in_valid & in_ready);
    assign grant_data = in_data[int'(grant) * WIDTH +: WIDTH];

    // Next-state: load on transfer, otherwise drop the word once consumed.
    // The pointer moves only on round-robin transfers.
    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_chan_d  = out_chan_q;
        rr_ptr_d    = rr_ptr_q;
        if (xfer) begin
            out_valid_d = 1'b1;
            out_data_d  = grant_data;
            out_chan_d  = grant;
            if (mode) begin
                rr_ptr_d = wrap_inc(grant);
            end
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    // State registers; reset clears the held word and restarts arbitration.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_chan_q  <= '0;
            rr_ptr_q    <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_chan_q  <= out_chan_d;
            rr_ptr_q    <= rr_ptr_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_chan  = out_chan_q;

endmodule
